// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video RAM arbiter, its two clients (scanout and CPU)
// and the synchronous video RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  // Scanout client
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              vga_overrun;
  // CPU client
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  // RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, vga_valid, vga_overrun, cpu_rdata, cpu_ack,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, vga_valid, vga_overrun, cpu_rdata, cpu_ack,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: fixed-priority scanout fetches over CPU
// accesses, two RAM cycles per transaction, never aborting an access.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    VGA_ADDR,
    VGA_DATA,
    CPU_ADDR,
    CPU_DATA
  } state_t;

  state_t              r_state;
  logic                r_vga_pend;
  logic                r_vga_overrun;
  logic [ADDR_W-1:0]   r_vga_addr_q;
  logic                r_cpu_we_q;
  logic [ADDR_W-1:0]   r_cpu_addr_q;
  logic [DATA_W-1:0]   r_cpu_wdata_q;

  // The VGA_ADDR cycle is the one slot where a new request may overwrite the
  // pending one: the old address is already on the RAM bus this cycle.
  logic w_vga_drop;
  assign w_vga_drop = bus.vga_req && r_vga_pend && (r_state != VGA_ADDR);

  // NOTE: every register here uses non-blocking assignment so all reads in
  // this block see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_vga_pend    <= 1'b0;
      r_vga_overrun <= 1'b0;
      r_vga_addr_q  <= '0;
      r_cpu_we_q    <= 1'b0;
      r_cpu_addr_q  <= '0;
      r_cpu_wdata_q <= '0;
    end else begin
      if (bus.vga_req) begin
        if (w_vga_drop) begin
          r_vga_overrun <= 1'b1;
        end else begin
          r_vga_pend   <= 1'b1;
          r_vga_addr_q <= bus.vga_addr;
        end
      end else if (r_state == VGA_ADDR) begin
        r_vga_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_vga_pend) begin
            r_state <= VGA_ADDR;
          end else if (bus.cpu_req) begin
            r_state       <= CPU_ADDR;
            r_cpu_we_q    <= bus.cpu_we;
            r_cpu_addr_q  <= bus.cpu_addr;
            r_cpu_wdata_q <= bus.cpu_wdata;
          end
        end
        VGA_ADDR: r_state <= VGA_DATA;
        VGA_DATA: r_state <= IDLE;
        CPU_ADDR: r_state <= CPU_DATA;
        CPU_DATA: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (r_state)
      VGA_ADDR: bus.mem_addr = r_vga_addr_q;
      CPU_ADDR: begin
        bus.mem_addr  = r_cpu_addr_q;
        bus.mem_we    = r_cpu_we_q;
        bus.mem_wdata = r_cpu_wdata_q;
      end
      default: ;
    endcase
  end

  assign bus.vga_valid   = (r_state == VGA_DATA);
  assign bus.cpu_ack     = (r_state == CPU_DATA);
  assign bus.vga_data    = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.vga_overrun = r_vga_overrun;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM and a
// fairness soak; cycle numbers in comments count from each scenario's first drive.
module tb_vram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   we_cnt;
  int   ack_cnt;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model with a side port for preloading contents.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    we_cnt  += int'(bus.mem_we);
    ack_cnt += int'(bus.cpu_ack);
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0005;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0007; bus.cpu_wdata = 16'hFFFF;
    step();
    step();
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 13'h0 || bus.mem_wdata !== 16'h0 ||
        bus.vga_valid !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.vga_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h valid=%b ack=%b ovr=%b, want all zero",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.vga_valid, bus.cpu_ack, bus.vga_overrun);
    end
    reset = 1'b0;
    bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    step();
    step();
    checks++;
    if (bus.mem_addr !== 13'h0 || bus.mem_we !== 1'b0 || bus.vga_valid !== 1'b0 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_req: addr=%h we=%b valid=%b ack=%b, want 0 0 0 0",
               bus.mem_addr, bus.mem_we, bus.vga_valid, bus.cpu_ack);
    end
  endtask

  task automatic test_idle_scan();
    preload(13'h0123, 16'hBEEF);
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0123;        // cycle 0
    step(); bus.vga_req = 1'b0;                          // cycle 1
    checks++;
    if (bus.mem_addr !== 13'h0 || bus.vga_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_c1: addr=%h valid=%b, want 0000 0", bus.mem_addr, bus.vga_valid);
    end
    step();                                              // cycle 2
    checks++;
    if (bus.mem_addr !== 13'h0123 || bus.mem_we !== 1'b0 || bus.vga_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_c2: addr=%h we=%b valid=%b, want 0123 0 0", bus.mem_addr, bus.mem_we, bus.vga_valid);
    end
    step();                                              // cycle 3
    checks++;
    if (bus.vga_valid !== 1'b1 || bus.vga_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL scan_c3: valid=%b data=%h, want 1 BEEF", bus.vga_valid, bus.vga_data);
    end
    step();                                              // cycle 4
    checks++;
    if (bus.vga_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_c4: valid=%b, want 0", bus.vga_valid);
    end
  endtask

  task automatic test_cpu_write_read();
    we_cnt = 0; ack_cnt = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = 16'h5A5A;
    step();                                              // cycle 1: CPU_ADDR
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'h1FFF || bus.mem_wdata !== 16'h5A5A || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_addr: we=%b addr=%h wdata=%h ack=%b, want 1 1FFF 5A5A 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack);
    end
    step();                                              // cycle 2: ack
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wr_ack: ack=%b we=%b, want 1 0", bus.cpu_ack, bus.mem_we);
    end
    step();                                              // cycle 3: renew as read
    bus.cpu_we = 1'b0; bus.cpu_wdata = 16'h0000;
    step();                                              // cycle 4: CPU_ADDR
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 13'h1FFF) begin
      errors++;
      $display("FAIL cpu_rd_addr: we=%b addr=%h, want 0 1FFF", bus.mem_we, bus.mem_addr);
    end
    step();                                              // cycle 5: ack
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL cpu_rd_ack: ack=%b rdata=%h, want 1 5A5A", bus.cpu_ack, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    step();
    step();
    checks++;
    if (we_cnt != 1 || ack_cnt != 2) begin
      errors++;
      $display("FAIL cpu_wr_rd_counts: we_cycles=%0d acks=%0d, want 1 2", we_cnt, ack_cnt);
    end
  endtask

  task automatic test_collision();
    preload(13'h0020, 16'hC0DE);
    preload(13'h0010, 16'h1234);
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0020;        // cycle 0
    step();                                              // cycle 1: pend and cpu_req meet in IDLE
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;
    step();                                              // cycle 2
    checks++;
    if (bus.mem_addr !== 13'h0020 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_vga_first: addr=%h ack=%b, want 0020 0", bus.mem_addr, bus.cpu_ack);
    end
    step();                                              // cycle 3
    checks++;
    if (bus.vga_valid !== 1'b1 || bus.vga_data !== 16'hC0DE) begin
      errors++;
      $display("FAIL coll_vga_valid: valid=%b data=%h, want 1 C0DE", bus.vga_valid, bus.vga_data);
    end
    step();                                              // cycle 4: IDLE grant
    step();                                              // cycle 5
    checks++;
    if (bus.mem_addr !== 13'h0010 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_cpu_addr: addr=%h ack=%b, want 0010 0", bus.mem_addr, bus.cpu_ack);
    end
    step();                                              // cycle 6: ack, +5 from cpu_req
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL coll_cpu_ack: ack=%b rdata=%h, want 1 1234", bus.cpu_ack, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    int valid_seen;
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0100;        // cycle 0
    step();
    bus.vga_addr = 13'h0200;                             // cycle 1: dropped
    step();
    bus.vga_req = 1'b0;                                  // cycle 2
    checks++;
    if (bus.vga_overrun !== 1'b1 || bus.mem_addr !== 13'h0100) begin
      errors++;
      $display("FAIL ovr_drop: ovr=%b addr=%h, want 1 0100", bus.vga_overrun, bus.mem_addr);
    end
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      valid_seen += int'(bus.vga_valid);
    end
    checks++;
    if (valid_seen != 1 || bus.vga_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: valids=%0d ovr=%b, want 1 1", valid_seen, bus.vga_overrun);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.vga_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_reset_clear: ovr=%b, want 0", bus.vga_overrun);
    end
    preload(13'h0300, 16'hAAAA);
    preload(13'h0400, 16'hBBBB);
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0300;        // cycle 0
    step(); bus.vga_req = 1'b0;                          // cycle 1
    step();                                              // cycle 2: VGA_ADDR
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0400;
    checks++;
    if (bus.mem_addr !== 13'h0300) begin
      errors++;
      $display("FAIL ovr_accept_old_addr: addr=%h, want 0300", bus.mem_addr);
    end
    step(); bus.vga_req = 1'b0;                          // cycle 3
    checks++;
    if (bus.vga_valid !== 1'b1 || bus.vga_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL ovr_accept_first: valid=%b data=%h, want 1 AAAA", bus.vga_valid, bus.vga_data);
    end
    step();                                              // cycle 4
    step();                                              // cycle 5
    checks++;
    if (bus.mem_addr !== 13'h0400) begin
      errors++;
      $display("FAIL ovr_accept_new_addr: addr=%h, want 0400", bus.mem_addr);
    end
    step();                                              // cycle 6
    checks++;
    if (bus.vga_valid !== 1'b1 || bus.vga_data !== 16'hBBBB || bus.vga_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_accept_second: valid=%b data=%h ovr=%b, want 1 BBBB 0",
               bus.vga_valid, bus.vga_data, bus.vga_overrun);
    end
    step();
  endtask

  task automatic test_reset_mid_cpu();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0040; bus.cpu_wdata = 16'h1111;
    step();                                              // cycle 1: CPU_ADDR
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: we=%b, want 1", bus.mem_we);
    end
    reset = 1'b1;
    step();                                              // cycle 2: back in IDLE
    reset = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.mem_addr !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_abort: we=%b ack=%b addr=%h, want 0 0 0000", bus.mem_we, bus.cpu_ack, bus.mem_addr);
    end
    step();                                              // cycle 3: restarted CPU_ADDR
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'h0040 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_restart: we=%b addr=%h ack=%b, want 1 0040 0", bus.mem_we, bus.mem_addr, bus.cpu_ack);
    end
    step();                                              // cycle 4
    checks++;
    if (bus.cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ack: ack=%b, want 1", bus.cpu_ack);
    end
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_fairness_soak();
    int vga_q[$];
    int cpu_start;
    int lat;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_start = 0;
    bus.cpu_req = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (bus.vga_valid) begin
        checks++;
        if (vga_q.size() == 0) begin
          errors++;
          $display("FAIL soak_vga_spurious: valid at cycle %0d with nothing outstanding", cyc);
        end else begin
          lat = cyc - vga_q.pop_front();
          if (lat > 5) begin
            errors++;
            $display("FAIL soak_vga_latency: %0d cycles at cycle %0d, want <= 5", lat, cyc);
          end
        end
      end else if (vga_q.size() != 0 && cyc - vga_q[0] > 8) begin
        checks++; errors++;
        $display("FAIL soak_vga_timeout: request from cycle %0d unserved at %0d", vga_q[0], cyc);
        void'(vga_q.pop_front());
      end
      if (bus.cpu_ack) begin
        checks++;
        lat = cyc - cpu_start;
        if (lat > 6) begin
          errors++;
          $display("FAIL soak_cpu_latency: %0d cycles at cycle %0d, want <= 6", lat, cyc);
        end
        cpu_start = cyc + 1;
      end else if (cyc - cpu_start > 8) begin
        checks++; errors++;
        $display("FAIL soak_cpu_timeout: request from cycle %0d unacked at %0d", cpu_start, cyc);
        cpu_start = cyc;
      end
      bus.cpu_we    = cyc[0];
      bus.cpu_addr  = ADDR_W'(cyc * 7);
      bus.cpu_wdata = DATA_W'(cyc);
      bus.vga_req   = (cyc % 8 == 0);
      bus.vga_addr  = ADDR_W'(cyc);
      if (bus.vga_req) vga_q.push_back(cyc);
      step();
    end
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.vga_overrun !== 1'b0) begin
      errors++;
      $display("FAIL soak_overrun: ovr=%b, want 0", bus.vga_overrun);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; we_cnt = 0; ack_cnt = 0;
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    test_reset();
    test_idle_scan();
    test_cpu_write_read();
    test_collision();
    test_overrun();
    test_reset_mid_cpu();
    test_fairness_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
